// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-precision unsigned adder that reuses a single 4-bit ripple-carry
// datapath. Operands are captured on the input handshake, then added one
// nibble per clock (least significant first) with the inter-nibble carry kept
// in a flop. The finished sum is presented with a valid/ready handshake and
// held until the consumer takes it.
//
// Parameters
//   NIBBLES   operand width in nibbles (W = 4*NIBBLES), legal range 1..16
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   operands/cin valid
//   in_ready   out  block can accept operands (high only when idle)
//   a, b       in   W-bit unsigned operands
//   cin        in   carry into nibble 0
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   sum        out  a+b+cin, low W bits
//   cout       out  carry out of the top nibble
//   ovf        out  signed overflow (present only when NSA_OVF_EN is defined)
//
// Configuration macro
//   NSA_OVF_EN  adds the ovf port and its signed-overflow logic
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder used as the shared nibble datapath.
module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    // Classic full-adder chain, bit 0 upward
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
`ifdef NSA_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [IW-1:0] idx;
    logic          carry;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    sum1;
    logic [3:0]    sum2;
    logic          cout1;
    logic          cout2;
    logic          carry_next;
    logic [W-1:0]  sum_next;

    // Pick the operand nibbles addressed by idx and merge the freshly
    // computed nibble into the running sum.
    always_comb begin
        a_nib    = '0;
        b_nib    = '0;
        sum_next = sum;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == i[IW-1:0]) begin
                a_nib               = a_reg[4*i +: 4];
                b_nib               = b_reg[4*i +: 4];
                sum_next[4*i +: 4]  = sum2;
            end
        end
    end

    // First adder sums the operand nibbles, the second folds in the stored
    // carry. Their carries can never both be set: if the first overflows its
    // sum is at most 0xE, so adding one more cannot overflow again.
    rca_4bit u_rca_ab (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (1'b0),
        .sum  (sum1),
        .cout (cout1)
    );

    rca_4bit u_rca_c (
        .a    (sum1),
        .b    ({3'b000, carry}),
        .cin  (1'b0),
        .sum  (sum2),
        .cout (cout2)
    );

    assign carry_next = cout1 | cout2;

    // Control FSM with registered handshake outputs. DONE always returns to
    // IDLE before a new accept, giving one bubble cycle per operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef NSA_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        cout     <= 1'b0;
`ifdef NSA_OVF_EN
                        ovf      <= 1'b0;
`endif
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum   <= sum_next;
                    carry <= carry_next;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= carry_next;
`ifdef NSA_OVF_EN
                        // sum2[3] is the new sign bit of the full result
                        ovf       <= (a_reg[W-1] == b_reg[W-1]) &&
                                     (sum2[3] != a_reg[W-1]);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed testbench for nibble_serial_adder with NIBBLES=4. Expected values
// are hand-computed constants. Define NSA_OVF_EN to also exercise the signed
// overflow output.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef NSA_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NSA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for in_ready, present one operation, then wait for the result
    // and confirm it appears exactly four cycles after the accept edge
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic tcin);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        a        = ta;
        b        = tb;
        cin      = tcin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
        checkVal("in_ready_low_in_run", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal("latency", n, 32'd4);
    endtask

    // Compare the presented result
    task automatic checkOutput(input string tag, input logic [15:0] exp_sum, input logic exp_cout);
        checkVal({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        checkVal({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
        checkVal({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    endtask

    // Consume the result and confirm the return to idle
    task automatic completeHandshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal({tag, "_out_valid_cleared"}, {31'd0, out_valid}, 32'd0);
        checkVal({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkVal("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("reset_sum", {16'd0, sum}, 32'd0);
        checkVal("reset_cout", {31'd0, cout}, 32'd0);
`ifdef NSA_OVF_EN
        checkVal("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;

        $display("[TB] zero plus zero");
        applyStimulus(16'h0000, 16'h0000, 1'b0);
        checkOutput("zero", 16'h0000, 1'b0);
        completeHandshake("zero");

        $display("[TB] carry through all nibbles");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        checkOutput("ripple", 16'h0000, 1'b1);
        completeHandshake("ripple");

        $display("[TB] carry-in cases");
        applyStimulus(16'h1234, 16'h4321, 1'b1);
        checkOutput("mixed", 16'h5556, 1'b0);
        completeHandshake("mixed");
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b1);
        checkOutput("alt", 16'h0000, 1'b1);
        completeHandshake("alt");

        $display("[TB] backpressure in DONE");
        applyStimulus(16'h00FF, 16'h0F01, 1'b0);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold", 16'h1000, 1'b0);
            checkVal("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        completeHandshake("hold");
        checkVal("idle_sum_kept", {16'd0, sum}, 32'h0000_1000);

        $display("[TB] reset mid-operation");
        a        = 16'h7777;
        b        = 16'h7777;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("midrun_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkVal("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkVal("abort_sum", {16'd0, sum}, 32'd0);
        checkVal("abort_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(16'h0F0F, 16'h0101, 1'b0);
        checkOutput("after_abort", 16'h1010, 1'b0);
        completeHandshake("after_abort");

`ifdef NSA_OVF_EN
        $display("[TB] signed overflow");
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        checkOutput("ovf_pos", 16'h8000, 1'b0);
        checkVal("ovf_pos_flag", {31'd0, ovf}, 32'd1);
        completeHandshake("ovf_pos");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        checkOutput("ovf_none", 16'h0000, 1'b1);
        checkVal("ovf_none_flag", {31'd0, ovf}, 32'd0);
        completeHandshake("ovf_none");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
